// File: rtl/ccff_loader_pkg.sv
// Shared types and default sizes for the configuration-chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ccff_loader_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int LEN_W_DEF  = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/ccff_chain_loader_packer.sv
// Packs bits captured from the chain tail into readback words (LSB first).
// Latency: a word is visible on rd_valid the cycle after its last bit is captured.
// Backpressure: one-entry output register; stall warns the loader before a push can collide.
module ccff_readback_packer #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              rb_en,
    input  logic              cap_en,
    input  logic              cap_last,
    input  logic              cap_tail,
    input  logic              next_last,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              stall
);

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W:0]   AHEAD_LAST = (CNT_W + 1)'(WORD_W - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic [WORD_W-1:0] word;
    logic [CNT_W:0]    ahead;

    // Capture one tail bit per shift edge; push a word when full or on the final bit.
    always_comb begin
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        rd_valid_d = rd_valid_q & ~rd_ready;
        rd_data_d  = rd_data_q;
        word       = cap_q | (WORD_W'(cap_tail) << cnt_q);
        if (rb_en && cap_en) begin
            if (cap_last || cnt_q == LAST_IDX) begin
                rd_valid_d = 1'b1;
                rd_data_d  = word;
                cap_d      = '0;
                cnt_d      = '0;
            end else begin
                cap_d = word;
                cnt_d = cnt_q + 1'b1;
            end
        end
        // The strobe being decided now is captured one edge later, after any
        // capture already in flight; stall it if it would push into a full register.
        ahead = {1'b0, cnt_q} + {{CNT_W{1'b0}}, cap_en};
        stall = rb_en & rd_valid_q & ~rd_ready & ((ahead == AHEAD_LAST) | next_last);
    end

    // Capture and output registers.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cnt_q      <= '0;
            cap_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host bitstream words LSB-first onto the configuration chain, with optional tail readback.
// Latency: start, word handshake, then strobes from the edge after the first SHIFT cycle.
// Backpressure: wr_ready only in FETCH; shifting stalls while a readback push would hit a full register.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic              rb_en,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
    localparam logic [LEN_W-1:0] ONE_BIT  = LEN_W'(1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rb_en_q, rb_en_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              ccff_head_q, ccff_head_d;
    logic              config_enable_q, config_enable_d;
    logic              last_q, last_d;
    logic              stall;
    logic              next_last;

    assign next_last = (state_q == SHIFT) && (rem_q == ONE_BIT);

    // Next-state and datapath control for the load sequence.
    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        rb_en_d         = rb_en_q;
        shreg_d         = shreg_q;
        idx_d           = idx_q;
        ccff_head_d     = ccff_head_q;
        config_enable_d = 1'b0;
        last_d          = 1'b0;
        wr_ready        = 1'b0;
        done            = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = chain_len;
                    rb_en_d = rb_en;
                    state_d = (chain_len == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    shreg_d = wr_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    config_enable_d = 1'b1;
                    ccff_head_d     = shreg_q[0];
                    last_d          = (rem_q == ONE_BIT);
                    shreg_d         = shreg_q >> 1;
                    rem_d           = rem_q - 1'b1;
                    idx_d           = idx_q + 1'b1;
                    if (rem_q == ONE_BIT) begin
                        state_d = FINISH;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = FETCH;
                    end
                end
            end
            FINISH: begin
                // Hold until the final strobe edge has passed so its readback bit is pushed.
                if (!config_enable_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q         <= IDLE;
            rem_q           <= '0;
            rb_en_q         <= 1'b0;
            shreg_q         <= '0;
            idx_q           <= '0;
            ccff_head_q     <= 1'b0;
            config_enable_q <= 1'b0;
            last_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rem_q           <= rem_d;
            rb_en_q         <= rb_en_d;
            shreg_q         <= shreg_d;
            idx_q           <= idx_d;
            ccff_head_q     <= ccff_head_d;
            config_enable_q <= config_enable_d;
            last_q          <= last_d;
        end
    end

    ccff_readback_packer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .rb_en     (rb_en_q),
        .cap_en    (config_enable_q),
        .cap_last  (last_q),
        .cap_tail  (ccff_tail),
        .next_last (next_last),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .stall     (stall)
    );

    assign ccff_head     = ccff_head_q;
    assign config_enable = config_enable_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for the chain loader with a loopback chain model and head/readback scoreboards.
// Latency: n/a.
// Backpressure: rd_ready driven directly to exercise readback stalls.
module tb_ccff_chain_loader;

    localparam int WW = 32;
    localparam int LW = 20;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic [LW-1:0] chain_len;
    logic          rb_en;
    logic          wr_valid;
    logic [WW-1:0] wr_data;
    logic          wr_ready;
    logic          ccff_head;
    logic          config_enable;
    logic          ccff_tail;
    logic          rd_valid;
    logic [WW-1:0] rd_data;
    logic          rd_ready;
    logic          busy;
    logic          done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Loopback chain: bit 0 is the tail, new bits enter at position clen-1.
    logic [63:0] chain_m = '0;
    logic [63:0] preload = '0;
    logic        load_chain = 1'b0;
    int          clen = 40;

    bit          exp_head[$];
    logic [31:0] exp_rd[$];
    int          gaps[$];
    int          strobes, dones, gap, bits_left;
    bit          seen_strobe, wr_ready_seen;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(WW), .LEN_W(LW)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .chain_len     (chain_len),
        .rb_en         (rb_en),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .ccff_tail     (ccff_tail),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .busy          (busy),
        .done          (done)
    );

    assign ccff_tail = chain_m[0];

    always @(posedge prog_clk) begin
        if (load_chain) chain_m <= preload;
        else if (config_enable) chain_m <= (chain_m >> 1) | ({63'b0, ccff_head} << (clen - 1));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Monitor: scoreboard head bits on each strobe and readback words on each pop.
    always @(negedge prog_clk) begin
        if (!pReset) begin
            if (config_enable) begin
                strobes++;
                if (seen_strobe && gap > 0) gaps.push_back(gap);
                gap = 0;
                seen_strobe = 1'b1;
                if (exp_head.size() == 0) check("head_extra", 64'(1), 64'(0));
                else check("head_bit", 64'(ccff_head), 64'(exp_head.pop_front()));
            end else if (seen_strobe) begin
                gap++;
            end
            if (done) dones++;
            if (wr_ready) wr_ready_seen = 1'b1;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) check("rd_extra", 64'(1), 64'(0));
                else check("rd_word", 64'(rd_data), 64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic start_load(input int len, input bit rb);
        strobes = 0; dones = 0; gap = 0; seen_strobe = 1'b0; wr_ready_seen = 1'b0;
        gaps.delete();
        bits_left = len;
        start = 1'b1; chain_len = LW'(len); rb_en = rb;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit got = 1'b0;
        for (int i = 0; i < WW; i++) begin
            if (bits_left > 0) begin
                exp_head.push_back(w[i]);
                bits_left--;
            end
        end
        wr_valid = 1'b1; wr_data = w;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge prog_clk);
            if (wr_ready) got = 1'b1;
        end
        tick();
        wr_valid = 1'b0;
        if (!got) check("wr_timeout", 64'(0), 64'(1));
    endtask

    // Returns at the negedge where done is high (or reports a timeout).
    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge prog_clk);
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic set_chain(input logic [63:0] v);
        preload = v; load_chain = 1'b1;
        tick();
        load_chain = 1'b0;
    endtask

    initial begin
        pReset = 1'b1; start = 1'b0; chain_len = '0; rb_en = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        tick(); tick();
        check("rst_wr_ready", 64'(wr_ready), 64'(0));
        check("rst_head", 64'(ccff_head), 64'(0));
        check("rst_cfg_en", 64'(config_enable), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_busy_done", 64'({busy, done}), 64'(0));
        pReset = 1'b0;
        tick();

        // Single short word.
        start_load(8, 1'b0);
        send_word(32'h0000_00A5);
        wait_done(100);
        check("t1_busy_at_done", 64'(busy), 64'(1));
        tick();
        check("t1_busy_after", 64'(busy), 64'(0));
        check("t1_done_after", 64'(done), 64'(0));
        check("t1_strobes", 64'(strobes), 64'(8));
        check("t1_dones", 64'(dones), 64'(1));
        check("t1_head_left", 64'(exp_head.size()), 64'(0));

        // Three words, 70 bits, partial last word.
        start_load(70, 1'b0);
        send_word(32'hFFFF_FFFF);
        send_word(32'h0000_0000);
        send_word(32'h0000_002A);
        wait_done(300);
        tick();
        check("t2_strobes", 64'(strobes), 64'(70));
        check("t2_gap_count", 64'(gaps.size()), 64'(2));
        if (gaps.size() == 2) begin
            check("t2_gap0", 64'(gaps[0]), 64'(1));
            check("t2_gap1", 64'(gaps[1]), 64'(1));
        end
        check("t2_head_left", 64'(exp_head.size()), 64'(0));

        // Loopback readback, unstalled host.
        clen = 40;
        set_chain(64'h5A_DEAD_BEEF);
        exp_rd.push_back(32'hDEAD_BEEF);
        exp_rd.push_back(32'h0000_005A);
        start_load(40, 1'b1);
        send_word(32'h1234_5678);
        send_word(32'h0000_00C3);
        wait_done(300);
        tick();
        check("t3_strobes", 64'(strobes), 64'(40));
        check("t3_rd_left", 64'(exp_rd.size()), 64'(0));
        check("t3_chain", 64'(chain_m[39:0]), 64'h00_C3_1234_5678);
        check("t3_rd_valid", 64'(rd_valid), 64'(0));

        // Readback with the host withholding rd_ready.
        set_chain(64'h5A_DEAD_BEEF);
        rd_ready = 1'b0;
        exp_rd.push_back(32'hDEAD_BEEF);
        exp_rd.push_back(32'h0000_005A);
        start_load(40, 1'b1);
        send_word(32'h0F0F_0F0F);
        send_word(32'h0000_0081);
        for (int c = 0; c < 200 && strobes < 39; c++) @(negedge prog_clk);
        repeat (10) tick();
        @(negedge prog_clk);
        check("t4_stalled_cfg_en", 64'(config_enable), 64'(0));
        check("t4_stalled_strobes", 64'(strobes), 64'(39));
        check("t4_stalled_rd_data", 64'(rd_data), 64'hDEAD_BEEF);
        tick();
        rd_ready = 1'b1;
        tick();
        @(negedge prog_clk);
        check("t4_resume", 64'(config_enable), 64'(1));
        wait_done(100);
        tick();
        check("t4_strobes", 64'(strobes), 64'(40));
        check("t4_rd_left", 64'(exp_rd.size()), 64'(0));
        check("t4_chain", 64'(chain_m[39:0]), 64'h00_81_0F0F_0F0F);

        // Zero-length load.
        start_load(0, 1'b0);
        wait_done(10);
        tick();
        check("t5_strobes", 64'(strobes), 64'(0));
        check("t5_wr_ready", 64'(wr_ready_seen), 64'(0));
        check("t5_dones", 64'(dones), 64'(1));

        // Start pulse while busy is ignored.
        start_load(8, 1'b0);
        send_word(32'h0000_003C);
        start = 1'b1; chain_len = LW'(100);
        tick();
        start = 1'b0;
        wait_done(100);
        repeat (4) tick();
        check("t6_strobes", 64'(strobes), 64'(8));
        check("t6_dones", 64'(dones), 64'(1));
        check("t6_busy", 64'(busy), 64'(0));

        // Reset in the middle of a 64-bit load.
        start_load(64, 1'b0);
        send_word(32'hFEDC_BA98);
        for (int c = 0; c < 100 && strobes < 10; c++) @(negedge prog_clk);
        tick();
        pReset = 1'b1;
        tick();
        check("t7_rst_outputs", 64'({wr_ready, ccff_head, config_enable, rd_valid, busy, done}), 64'(0));
        check("t7_rst_rd_data", 64'(rd_data), 64'(0));
        pReset = 1'b0;
        exp_head.delete();
        bits_left = 0;
        repeat (5) tick();
        check("t7_no_done", 64'(dones), 64'(0));
        start_load(64, 1'b0);
        send_word(32'h1357_9BDF);
        send_word(32'h2468_ACE0);
        wait_done(200);
        tick();
        check("t7_strobes", 64'(strobes), 64'(64));
        check("t7_dones", 64'(dones), 64'(1));
        check("t7_head_left", 64'(exp_head.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
